// File: rtl/bch_32_bits_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bch_32_bits_seq_ctrl_if
// Purpose  : Word in/out handshake plus shared-decoder links for the
//            time-multiplexed 72-bit BCH(15,7) decode scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface bch_32_bits_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] data_in;
  logic [14:0] dec_codeword;
  logic [14:0] dec_corrected;
  logic        dec_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] codeword_out;
  logic        error_detected;
  logic [4:0]  err_mask;
  logic        busy;

  // Controller side
  modport slave (
    input  in_valid, data_in, dec_corrected, dec_error, out_ready,
    output in_ready, dec_codeword, out_valid, codeword_out, error_detected,
           err_mask, busy
  );

  // Environment side: word source/sink and the shared decoder
  modport master (
    output in_valid, data_in, dec_corrected, dec_error, out_ready,
    input  in_ready, dec_codeword, out_valid, codeword_out, error_detected,
           err_mask, busy
  );
endinterface
`default_nettype wire

// File: rtl/bch_32_bits_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bch_32_bits_seq_ctrl
// Purpose  : Issues the five 15-bit chunks of a 72-bit word to one shared
//            BCH(15,7) decoder and gathers the corrected data bits.
// Revision : 1.0  initial release
// ============================================================================
module bch_32_bits_seq_ctrl #(
  parameter int DEC_LAT = 2,
  parameter int NBLK    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  bch_32_bits_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] C_LAST = 3'(NBLK - 1);

  state_t            r_state;
  logic [71:0]       r_word;
  logic [2:0]        r_k;
  logic [14:0]       r_dec_cw;
  logic [DEC_LAT-1:0] r_trk_vld;
  logic [2:0]        r_trk_idx [DEC_LAT];
  logic [6:0]        r_res [NBLK];
  logic [NBLK-1:0]   r_err;
  logic              r_out_valid;
  logic [31:0]       r_cw_out;
  logic [NBLK-1:0]   r_err_mask;
  logic              r_err_det;

  logic [6:0]        w_res [NBLK];
  logic [NBLK-1:0]   w_err;
  logic              w_tail_vld;
  logic [2:0]        w_tail_idx;
  logic              w_last_ret;
  logic              w_unused;

  function automatic logic [14:0] chunk_of(input logic [71:0] word,
                                           input logic [2:0]  k);
    case (k)
      3'd0:    chunk_of = word[14:0];
      3'd1:    chunk_of = word[29:15];
      3'd2:    chunk_of = word[44:30];
      3'd3:    chunk_of = word[59:45];
      default: chunk_of = {3'b000, word[71:60]};
    endcase
  endfunction

  // Merge the returning chunk into the result slots so DONE can be entered
  // on the very edge that captures the last chunk.
  always_comb begin
    w_tail_vld = r_trk_vld[DEC_LAT-1];
    w_tail_idx = r_trk_idx[DEC_LAT-1];
    w_res      = r_res;
    w_err      = r_err;
    if (w_tail_vld) begin
      w_res[w_tail_idx] = bus.dec_corrected[14:8];
      w_err[w_tail_idx] = bus.dec_error;
    end
    w_last_ret = w_tail_vld && (w_tail_idx == C_LAST);
  end

  // Parity bits of the corrected codeword carry no data
  assign w_unused = ^bus.dec_corrected[7:0];

  assign bus.in_ready       = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.dec_codeword   = r_dec_cw;
  assign bus.out_valid      = r_out_valid;
  assign bus.codeword_out   = r_cw_out;
  assign bus.err_mask       = r_err_mask;
  assign bus.error_detected = r_err_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_k         <= '0;
      r_dec_cw    <= '0;
      r_trk_vld   <= '0;
      for (int i = 0; i < DEC_LAT; i++) r_trk_idx[i] <= '0;
      for (int i = 0; i < NBLK; i++)    r_res[i]     <= '0;
      r_err       <= '0;
      r_out_valid <= 1'b0;
      r_cw_out    <= '0;
      r_err_mask  <= '0;
      r_err_det   <= 1'b0;
    end else begin
      for (int i = DEC_LAT - 1; i > 0; i--) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_idx[i] <= r_trk_idx[i-1];
      end
      r_trk_vld[0] <= (r_state == S_ISSUE);
      r_trk_idx[0] <= r_k;
      r_res        <= w_res;
      r_err        <= w_err;

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_word   <= bus.data_in;
            r_k      <= '0;
            r_dec_cw <= bus.data_in[14:0];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_k == C_LAST) begin
            r_k      <= '0;
            r_dec_cw <= '0;
            r_state  <= S_DRAIN;
          end else begin
            r_k      <= r_k + 3'd1;
            r_dec_cw <= chunk_of(r_word, r_k + 3'd1);
          end
        end
        S_DRAIN: begin
          if (w_last_ret) begin
            r_out_valid <= 1'b1;
            r_cw_out    <= {w_res[4][3:0], w_res[3], w_res[2], w_res[1], w_res[0]};
            r_err_mask  <= w_err;
            r_err_det   <= |w_err;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_cw_out    <= '0;
            r_err_mask  <= '0;
            r_err_det   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bch_32_bits_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_32_bits_seq_ctrl
// Purpose  : Directed table-driven bench with a BCH(15,7) decoder model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bch_32_bits_seq_ctrl;

  typedef struct {
    logic [4:0][6:0]  d;     // data per chunk (chunk 4 uses [3:0])
    logic [4:0][14:0] e;     // injected error pattern per chunk
    logic [4:0]       mask;  // expected err_mask
  } vec_t;

  vec_t vecs [5];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          acc_cyc = 0;
  bit          sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [71:0] data_in = '0;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_32_bits_seq_ctrl_if bus2();
  bch_32_bits_seq_ctrl_if bus3();

  bch_32_bits_seq_ctrl #(.DEC_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  bch_32_bits_seq_ctrl #(.DEC_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus2.in_valid  = in_valid & ~sel;
  assign bus3.in_valid  = in_valid & sel;
  assign bus2.data_in   = data_in;
  assign bus3.data_in   = data_in;
  assign bus2.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  // Syndrome of a 15-bit word w.r.t. g(x) = x^8+x^7+x^6+x^4+1
  function automatic logic [7:0] rem8(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (15'h1D1 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [14:0] encode(input logic [6:0] d);
    return {d, rem8({d, 8'h00})};
  endfunction

  // Brute-force two-error decoder: returns {error_flag, corrected}
  function automatic logic [15:0] bch_fix(input logic [14:0] cw);
    logic [7:0]  s;
    logic [14:0] p;
    s = rem8(cw);
    if (s == 8'h00) return {1'b0, cw};
    for (int i = 0; i < 15; i++) begin
      p = 15'd1 << i;
      if (rem8(p) == s) return {1'b1, cw ^ p};
    end
    for (int i = 0; i < 15; i++)
      for (int j = i + 1; j < 15; j++) begin
        p = (15'd1 << i) | (15'd1 << j);
        if (rem8(p) == s) return {1'b1, cw ^ p};
      end
    return {1'b1, cw};
  endfunction

  logic [15:0] dl2 [2];
  logic [15:0] dl3 [3];
  always @(posedge clk) begin
    dl2[0] <= bch_fix(bus2.dec_codeword);
    dl2[1] <= dl2[0];
    dl3[0] <= bch_fix(bus3.dec_codeword);
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end
  assign bus2.dec_corrected = dl2[1][14:0];
  assign bus2.dec_error     = dl2[1][15];
  assign bus3.dec_corrected = dl3[2][14:0];
  assign bus3.dec_error     = dl3[2][15];

  logic        m_in_ready, m_out_valid, m_err_det, m_busy;
  logic [14:0] m_dec_cw;
  logic [31:0] m_cw_out;
  logic [4:0]  m_err_mask;
  assign m_in_ready  = sel ? bus3.in_ready       : bus2.in_ready;
  assign m_out_valid = sel ? bus3.out_valid      : bus2.out_valid;
  assign m_err_det   = sel ? bus3.error_detected : bus2.error_detected;
  assign m_busy      = sel ? bus3.busy           : bus2.busy;
  assign m_dec_cw    = sel ? bus3.dec_codeword   : bus2.dec_codeword;
  assign m_cw_out    = sel ? bus3.codeword_out   : bus2.codeword_out;
  assign m_err_mask  = sel ? bus3.err_mask       : bus2.err_mask;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack_word(input logic [4:0][14:0] ch);
    return {ch[4][11:0], ch[3], ch[2], ch[1], ch[0]};
  endfunction

  // Entered and left at #1 after a rising edge with the selected DUT idle
  task automatic run_word(input logic [4:0][14:0] ch, input logic [31:0] exp_cw,
                          input logic [4:0] exp_mask, input bit chk_out, input string tag);
    int lat;
    int exp_lat;
    exp_lat   = sel ? 9 : 8;
    data_in   = pack_word(ch);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, m_in_ready, 1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    data_in  = {9{8'hA5}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("%s chunk%0d", tag, k), m_dec_cw, ch[k]);
    end
    @(negedge clk);
    lat = 6;
    check({tag, " dec_codeword idle"}, m_dec_cw, 0);
    while (!m_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    if (chk_out) begin
      check({tag, " codeword_out"}, m_cw_out, exp_cw);
      check({tag, " err_mask"}, m_err_mask, exp_mask);
      check({tag, " error_detected"}, m_err_det, |exp_mask);
    end
    @(posedge clk); #1;
    check({tag, " after transfer"}, {m_out_valid, m_busy, m_cw_out, m_err_mask, m_err_det}, 0);
  endtask

  function automatic logic [4:0][14:0] vec_chunks(input vec_t v);
    logic [4:0][14:0] ch;
    for (int k = 0; k < 5; k++) ch[k] = encode(v.d[k]) ^ v.e[k];
    return ch;
  endfunction

  function automatic logic [31:0] vec_cw(input vec_t v);
    return {v.d[4][3:0], v.d[3], v.d[2], v.d[1], v.d[0]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0][14:0] ch;
    logic [71:0]      w;
    int               lat;
    int               prev_acc;

    vecs[0].d = '0;
    vecs[0].e = '0;
    vecs[0].mask = 5'b00000;
    vecs[1].d = {7'h0F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[1].e = '0;
    vecs[1].mask = 5'b00000;
    vecs[2].d = {7'h0A, 7'h64, 7'h13, 7'h2A, 7'h55};
    vecs[2].e = {15'h0000, 15'h0101, 15'h0000, 15'h0000, 15'h4000};
    vecs[2].mask = 5'b01001;
    vecs[3].d = {7'h01, 7'h08, 7'h04, 7'h02, 7'h01};
    vecs[3].e = {15'h0800, 15'h2004, 15'h0200, 15'h0080, 15'h0001};
    vecs[3].mask = 5'b11111;
    vecs[4].d = {7'h05, 7'h11, 7'h7F, 7'h00, 7'h3C};
    vecs[4].e = {15'h0000, 15'h0000, 15'h0008, 15'h0000, 15'h0000};
    vecs[4].mask = 5'b00100;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {bus2.out_valid, bus2.codeword_out, bus2.err_mask,
                            bus2.error_detected, bus2.dec_codeword, bus2.busy}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", {bus2.in_ready, bus3.in_ready}, 2'b11);
    check("post-reset idle", {bus2.out_valid, bus2.busy, bus3.out_valid, bus3.busy}, 0);

    // All-zero word
    ch = '0;
    run_word(ch, 32'h0, 5'b00000, 1'b1, "zero");

    // Chunk ordering
    ch = {15'h0804, 15'h1003, 15'h1002, 15'h1001, 15'h1000};
    run_word(ch, 32'h0, 5'b00000, 1'b0, "order");

    // Table vectors
    for (int i = 0; i < 5; i++)
      run_word(vec_chunks(vecs[i]), vec_cw(vecs[i]), vecs[i].mask, 1'b1,
               $sformatf("vec%0d", i));

    // Single error in chunk 2 of the all-zero codeword
    w = 72'h8 << 30;
    for (int k = 0; k < 4; k++) ch[k] = w[15*k +: 15];
    ch[4] = {3'b000, w[71:60]};
    run_word(ch, 32'h0, 5'b00100, 1'b1, "blk2err");

    // Back-pressure: DONE held for 10 cycles, in_valid pulses ignored
    ch        = vec_chunks(vecs[2]);
    data_in   = pack_word(ch);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold latency", lat, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold cycle%0d", i),
            {m_out_valid, m_in_ready, m_busy, m_dec_cw, m_cw_out, m_err_mask},
            {1'b1, 1'b0, 1'b1, 15'h0, vec_cw(vecs[2]), vecs[2].mask});
      @(posedge clk); #1;
      in_valid = (i % 3 == 0);
      data_in  = {9{8'h3C}};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold release", {m_out_valid, m_busy, m_in_ready, m_cw_out, m_err_mask}, 39'h1 << 37);
    @(posedge clk); #1;
    check("hold no accept", {m_busy, m_dec_cw}, 0);

    // Reset while issuing chunk 2, then a clean word
    ch       = vec_chunks(vecs[3]);
    data_in  = pack_word(ch);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset chunk2", m_dec_cw, ch[2]);
    #1 rst = 1'b0;
    #1;
    check("mid reset outputs", {m_out_valid, m_cw_out, m_err_mask, m_err_det, m_dec_cw, m_busy}, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    ch = '0;
    run_word(ch, 32'h0, 5'b00000, 1'b1, "after-reset");

    // DEC_LAT=3 instance, three back-to-back words
    sel = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      prev_acc = acc_cyc;
      run_word(vec_chunks(vecs[i]), vec_cw(vecs[i]), vecs[i].mask, 1'b1,
               $sformatf("lat3 word%0d", i));
      if (i > 1) check($sformatf("lat3 spacing%0d", i), acc_cyc - prev_acc, 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
